// File: rtl/flex_counter_adv.sv
// Parametrised up/down counter with sync clear, parallel load, wrap/saturate
// behaviour at the terminal count and a saturating tally of wrap events.
module flex_counter_adv #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     sat_mode,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [WRAP_CNT_BITS-1:0] WRAP_MAX = '1;

  logic [NUM_CNT_BITS-1:0]  count_next;
  logic                     wrap_event;
  logic                     range_valid;
  logic [NUM_CNT_BITS-1:0]  terminal_val;
  logic [WRAP_CNT_BITS-1:0] wrap_count_next;

  assign range_valid  = (rollover_val != CNT_ZERO);
  assign terminal_val = count_down ? CNT_ONE : rollover_val;

  // Up mode wraps straight to 1 so a full-range R never passes through 0.
  always_comb begin
    count_next = count_out;
    wrap_event = 1'b0;
    if (clear) begin
      count_next = CNT_ZERO;
    end else if (load) begin
      count_next = load_val;
    end else if (count_enable && range_valid) begin
      if (!count_down) begin
        if (count_out < rollover_val) begin
          count_next = count_out + CNT_ONE;
        end else if (!sat_mode) begin
          count_next = CNT_ONE;
          wrap_event = 1'b1;
        end else begin
          count_next = rollover_val;
        end
      end else begin
        if ((count_out == CNT_ZERO) || (count_out > rollover_val)) begin
          count_next = rollover_val;
        end else if (count_out > CNT_ONE) begin
          count_next = count_out - CNT_ONE;
        end else if (!sat_mode) begin
          count_next = rollover_val;
          wrap_event = 1'b1;
        end else begin
          count_next = CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    wrap_count_next = wrap_count;
    if (clear) begin
      wrap_count_next = '0;
    end else if (wrap_event && (wrap_count != WRAP_MAX)) begin
      wrap_count_next = wrap_count + WRAP_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      count_out  <= count_next;
      wrap_pulse <= wrap_event;
      wrap_count <= wrap_count_next;
    end
  end

  assign rollover_flag = range_valid && (count_out == terminal_val);

endmodule

// File: tb/tb_flex_counter_adv.sv
// Self-checking bench for flex_counter_adv: directed scenarios plus random
// traffic, checked against an integer reference model of the counting rules.
module tb_flex_counter_adv;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic       count_down;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [3:0] count_out2;
  logic       rollover_flag2;
  logic       wrap_pulse2;
  logic [1:0] wrap_count2;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_cnt = 0;
  int m_wc  = 0;
  int m_wc2 = 0;
  bit m_wp  = 0;

  flex_counter_adv #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  flex_counter_adv #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .rollover_val(rollover_val), .count_out(count_out2),
    .rollover_flag(rollover_flag2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next state from the rules, using the inputs as they stand before the edge
  function automatic void modelEdge();
    int c;
    int r;
    bit ev;
    c  = m_cnt;
    r  = int'(rollover_val);
    ev = 1'b0;
    if (clear) begin
      m_cnt = 0; m_wc = 0; m_wc2 = 0; m_wp = 1'b0;
      return;
    end
    if (load) begin
      m_cnt = int'(load_val); m_wp = 1'b0;
      return;
    end
    if (count_enable && r != 0) begin
      if (!count_down) begin
        if (c < r) c = c + 1;
        else if (sat_mode) c = r;
        else begin c = 1; ev = 1'b1; end
      end else begin
        if (c == 0 || c > r) c = r;
        else if (c > 1) c = c - 1;
        else if (!sat_mode) begin c = r; ev = 1'b1; end
      end
    end
    m_cnt = c;
    m_wp  = ev;
    if (ev) begin
      if (m_wc < 255) m_wc = m_wc + 1;
      if (m_wc2 < 3) m_wc2 = m_wc2 + 1;
    end
  endfunction

  function automatic bit modelFlag();
    int t;
    t = count_down ? 1 : int'(rollover_val);
    return (rollover_val != 0) && (m_cnt == t);
  endfunction

  task automatic checkValue(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".count"},   int'(count_out),      m_cnt);
    checkValue({tag, ".flag"},    int'(rollover_flag),  int'(modelFlag()));
    checkValue({tag, ".pulse"},   int'(wrap_pulse),     int'(m_wp));
    checkValue({tag, ".wcount"},  int'(wrap_count),     m_wc);
    checkValue({tag, ".count2"},  int'(count_out2),     m_cnt);
    checkValue({tag, ".pulse2"},  int'(wrap_pulse2),    int'(m_wp));
    checkValue({tag, ".wcount2"}, int'(wrap_count2),    m_wc2);
  endtask

  // Drive one edge worth of inputs, advance model and DUT, sample 1 after the edge
  task automatic applyStimulus(input bit clr, input bit ld, input int lv,
                               input bit en, input bit dn, input bit sat, input int r);
    clear        = clr;
    load         = ld;
    load_val     = 4'(lv);
    count_enable = en;
    count_down   = dn;
    sat_mode     = sat;
    rollover_val = 4'(r);
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int exp_up[12];
    int exp_dn[7];
    int pulses;
    bit dn_r, sat_r;
    int r_r;
    exp_up = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    exp_dn = '{3, 2, 1, 3, 2, 1, 3};

    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    count_enable = 1'b0; count_down = 1'b0; sat_mode = 1'b0; rollover_val = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset.count", int'(count_out), 0);
    checkValue("reset.flag", int'(rollover_flag), 0);
    checkValue("reset.wcount", int'(wrap_count), 0);
    n_rst = 1'b1;

    // 1: up wrap R=5
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 5);
      checkValue("t1.seq", int'(count_out), exp_up[i]);
      checkValue("t1.flag", int'(rollover_flag), int'(exp_up[i] == 5));
      checkOutput("t1");
      if (wrap_pulse) pulses++;
    end
    checkValue("t1.pulses", pulses, 2);
    checkValue("t1.wcount", int'(wrap_count), 2);

    // 2: down wrap R=3 from 0
    applyStimulus(1, 0, 0, 0, 1, 0, 3);
    checkOutput("t2.clr");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0, 3);
      checkValue("t2.seq", int'(count_out), exp_dn[i]);
      checkValue("t2.flag", int'(rollover_flag), int'(exp_dn[i] == 1));
      checkOutput("t2");
    end
    checkValue("t2.wcount", int'(wrap_count), 2);

    // 3: up saturate R=4
    applyStimulus(1, 0, 0, 0, 0, 1, 4);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 1, 4);
      checkValue("t3.seq", int'(count_out), (i < 4) ? i + 1 : 4);
      checkOutput("t3");
    end
    checkValue("t3.flag", int'(rollover_flag), 1);
    checkValue("t3.wcount", int'(wrap_count), 0);

    // 4: priority clear > load > enable
    applyStimulus(1, 0, 0, 0, 0, 0, 5);
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 0, 5);
    checkValue("t4.pre", int'(count_out), 3);
    applyStimulus(1, 1, 7, 1, 0, 0, 5);
    checkValue("t4.clr", int'(count_out), 0);
    checkValue("t4.clrw", int'(wrap_count), 0);
    applyStimulus(0, 1, 9, 1, 0, 0, 5);
    checkValue("t4.load", int'(count_out), 9);
    checkOutput("t4");

    // 5: full-range wrap, out-of-range wrap, disabled counter
    applyStimulus(0, 1, 14, 0, 0, 0, 15);
    applyStimulus(0, 0, 0, 1, 0, 0, 15);
    checkValue("t5.r15a", int'(count_out), 15);
    applyStimulus(0, 0, 0, 1, 0, 0, 15);
    checkValue("t5.r15b", int'(count_out), 1);
    checkOutput("t5.r15");
    applyStimulus(0, 1, 9, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 1, 0, 0, 2);
    checkValue("t5.r2", int'(count_out), 1);
    checkOutput("t5.r2");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkValue("t5.r0", int'(count_out), 1);
    checkValue("t5.r0f", int'(rollover_flag), 0);
    checkOutput("t5.r0");

    // 6: async reset mid-count, then small tally saturation
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 0, 1);
    checkValue("t6.prepulse", int'(wrap_pulse), 1);
    #2 n_rst = 1'b0;
    #1;
    checkValue("t6.rst.count", int'(count_out), 0);
    checkValue("t6.rst.pulse", int'(wrap_pulse), 0);
    checkValue("t6.rst.wcount", int'(wrap_count), 0);
    m_cnt = 0; m_wc = 0; m_wc2 = 0; m_wp = 1'b0;
    #1 n_rst = 1'b1;
    repeat (6) applyStimulus(0, 0, 0, 1, 0, 0, 1);
    checkValue("t6.wc8", int'(wrap_count), 5);
    checkValue("t6.wc2", int'(wrap_count2), 3);
    checkOutput("t6");

    // random traffic against the model
    dn_r = 1'b0; sat_r = 1'b0; r_r = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) r_r = int'($urandom_range(15));
      if ($urandom_range(7) == 0) dn_r = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) sat_r = 1'($urandom_range(1));
      applyStimulus($urandom_range(19) == 0, $urandom_range(9) == 0,
                    int'($urandom_range(15)), $urandom_range(3) != 0,
                    dn_r, sat_r, r_r);
      checkOutput("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
